tst2_chk: RTL and testbench

TST2_CHK -- requirements
Module: tst2_chk

---
 rtl/tst2_chk.sv | 74 +++++++
 tb/tb_tst2_chk.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tst2_chk.sv
// tst2_chk: incrementing-byte test pattern checker with acquire/verify/track lock FSM and saturating error count
module tst2_chk #(
  parameter int RUN_W = 8,
  parameter int LOSS_N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d,
  input  logic        clr,
  output logic        lock,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [1:0]  st
);
  localparam int MW = $clog2(LOSS_N + 1);
  typedef enum logic [1:0] {ACQ = 2'd0, VERIFY = 2'd1, TRACK = 2'd2} state_t;
  state_t state;
  logic [7:0] d_r, d_p, exp_v;
  logic [RUN_W-1:0] ph;
  logic [MW-1:0] miss;
  logic match, run_end, hit, last;
  assign st = state;
  assign match = d_r == exp_v;
  assign run_end = &ph;
  assign hit = state == TRACK && !match;
  assign last = miss == MW'(LOSS_N - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACQ;
      lock <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      miss <= '0;
      ph <= '0;
      exp_v <= '0;
      d_r <= '0;
      d_p <= '0;
    end else begin
      d_r <= d;
      d_p <= d_r;
      err <= hit;
      err_cnt <= clr ? '0 : (hit && ~&err_cnt) ? err_cnt + 16'd1 : err_cnt;
      case (state)
        ACQ: if (d_r == d_p + 8'd1) begin
          exp_v <= d_r;
          ph <= RUN_W'(1);
          state <= VERIFY;
        end
        VERIFY, TRACK: begin
          // flywheel: expected byte advances at run end whatever the compare says
          ph <= ph + RUN_W'(1);
          if (run_end) exp_v <= exp_v + 8'd1;
          if (state == VERIFY) begin
            if (!match) state <= ACQ;
            else if (run_end) begin
              state <= TRACK;
              lock <= 1'b1;
            end
          end else if (!match) begin
            if (last) begin
              state <= ACQ;
              lock <= 1'b0;
              miss <= '0;
            end else miss <= miss + MW'(1);
          end else miss <= '0;
        end
        default: begin
          state <= ACQ;
          lock <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tst2_chk.sv
// tb_tst2_chk: randomized pattern stream against a sample-rule reference model, plus a saturation run on a wide-LOSS_N instance
module tb_tst2_chk;
  localparam int RUN = 256;
  localparam int LOSS = 4;
  logic clk = 0, rst = 1, clr = 0, rst2 = 1, clr2 = 0;
  logic [7:0] d = 0, d2 = 0;
  logic lock, err, lock2, err2;
  logic [15:0] err_cnt, err_cnt2;
  logic [1:0] st, st2;
  int n_vec = 0, n_err = 0;
  logic [7:0] gv, g2v;
  int gc, g2c;
  int m_dr, m_dp, m_st, m_exp, m_ph, m_miss, m_cnt, m_err;

  always #5 clk = ~clk;

  tst2_chk #(.RUN_W(8), .LOSS_N(LOSS)) dut (
    .clk(clk), .rst(rst), .d(d), .clr(clr),
    .lock(lock), .err(err), .err_cnt(err_cnt), .st(st)
  );
  // loss threshold far above 65536 so lock survives a full saturation run
  tst2_chk #(.RUN_W(8), .LOSS_N(1 << 17)) dut2 (
    .clk(clk), .rst(rst2), .d(d2), .clr(clr2),
    .lock(lock2), .err(err2), .err_cnt(err_cnt2), .st(st2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    int nst, nexp, nph;
    logic hit;
    if (rst) begin
      {m_dr, m_dp, m_st, m_exp, m_ph, m_miss, m_cnt, m_err} = '0;
      return;
    end
    nst = m_st; nexp = m_exp; nph = m_ph; m_err = 0; hit = 0;
    if (m_st == 0) begin
      if (m_dr == (m_dp + 1) % 256) begin nexp = m_dr; nph = 1; nst = 1; end
    end else begin
      nph = (m_ph + 1) % RUN;
      if (m_ph == RUN - 1) nexp = (m_exp + 1) % 256;
      if (m_st == 1) nst = (m_dr != m_exp) ? 0 : (m_ph == RUN - 1) ? 2 : 1;
      else if (m_dr != m_exp) begin
        hit = 1;
        m_miss++;
        if (m_miss == LOSS) begin nst = 0; m_miss = 0; end
      end else m_miss = 0;
    end
    m_err = hit;
    if (hit && m_cnt < 65535) m_cnt++;
    if (clr) m_cnt = 0;
    m_dp = m_dr; m_dr = d; m_st = nst; m_exp = nexp; m_ph = nph;
  endtask

  task automatic sample(input logic [7:0] b);
    d = b;
    @(posedge clk);
    model_step();
    #1;
    chk("st", st, m_st);
    chk("lock", lock, m_st == 2);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  task automatic adv();
    gc++;
    if (gc == RUN) begin gc = 0; gv++; end
  endtask

  task automatic good(input int n);
    repeat (n) begin sample(gv); adv(); end
  endtask

  task automatic bad();
    sample(gv ^ 8'($urandom_range(255, 1)));
    adv();
  endtask

  task automatic drive2(input logic [7:0] b);
    d2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic good2();
    drive2(g2v);
    g2c++;
    if (g2c == RUN) begin g2c = 0; g2v++; end
  endtask

  task automatic bad2();
    drive2(g2v ^ 8'h80);
    g2c++;
    if (g2c == RUN) begin g2c = 0; g2v++; end
  endtask

  task automatic main_seq();
    int k;
    rst = 1;
    good(3);
    chk("rst_st", st, 0);
    chk("rst_cnt", err_cnt, 0);
    rst = 0; gv = 8'h12; gc = 100;
    good(800);
    chk("mid_run_lock", lock, 1);
    chk("mid_run_cnt", err_cnt, 0);
    rst = 1; good(1); rst = 0;
    gv = 8'hFD; gc = 50;
    repeat (1000) begin
      clr = $urandom_range(49) == 0;
      sample(gv); adv();
    end
    clr = 0;
    chk("wrap_lock", lock, 1);
    chk("wrap_cnt", err_cnt, 0);
    rst = 1; good(1); rst = 0;
    gv = 8'h3E; gc = 0;
    while (!(gv == 8'h40 && gc == 20)) good(1);
    chk("pre_55_lock", lock, 1);
    sample(8'h55); adv();
    good(1);
    chk("single_err", err, 1);
    chk("single_cnt", err_cnt, 1);
    chk("single_lock", lock, 1);
    good(300);
    clr = 1; good(1); clr = 0;
    repeat (LOSS) bad();
    good(1);
    chk("loss_lock", lock, 0);
    chk("loss_cnt", err_cnt, 4);
    good(700);
    chk("reacq_lock", lock, 1);
    chk("reacq_cnt", err_cnt, 4);
    clr = 1; good(1); clr = 0;
    repeat (3) begin bad(); good(5); end
    chk("pre_rst_cnt", err_cnt, 3);
    rst = 1; good(1); rst = 0;
    chk("mid_rst_st", st, 0);
    chk("mid_rst_lock", lock, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    k = 0;
    while (st != 1 && k < 1000) begin good(1); k++; end
    chk("verify_reached", st, 1);
    good(5); bad(); good(1);
    chk("verify_miss_err", err, 0);
    chk("verify_miss_st", st, 0);
    good(50);
    repeat (3000) begin
      clr = $urandom_range(99) == 0;
      rst = $urandom_range(1999) == 0;
      if ($urandom_range(63) == 0) bad(); else good(1);
    end
    clr = 0; rst = 0;
  endtask

  task automatic sat_seq();
    rst2 = 1;
    drive2(0); drive2(0);
    chk("sat_rst_cnt", err_cnt2, 0);
    rst2 = 0; g2v = 8'h20; g2c = 0;
    repeat (800) good2();
    chk("sat_lock", lock2, 1);
    repeat (1000) bad2();
    good2();
    chk("sat_partial", err_cnt2, 1000);
    repeat (64535) bad2();
    good2();
    chk("sat_full", err_cnt2, 16'hFFFF);
    chk("sat_full_err", err2, 1);
    chk("sat_full_lock", lock2, 1);
    bad2(); good2();
    chk("sat_hold", err_cnt2, 16'hFFFF);
    chk("sat_hold_err", err2, 1);
    bad2();
    clr2 = 1; good2(); clr2 = 0;
    chk("clr_wins_cnt", err_cnt2, 0);
    chk("clr_wins_err", err2, 1);
    good2();
    chk("after_clr_err", err2, 0);
    chk("after_clr_cnt", err_cnt2, 0);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
